// File: rtl/uart_start_bit_validator.sv
// rtl/uart_start_bit_validator.sv - Rx start-bit detector with 3-sample majority vote and frame lockout
module uart_start_bit_validator #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_tick,
    input  logic serial_in,
    output logic start_detected,
    output logic false_start,
    output logic busy
);
    localparam int H  = OVERSAMPLE / 2;
    localparam int L  = (FRAME_BITS - 1) * OVERSAMPLE - 1;
    localparam int CW = $clog2(FRAME_BITS * OVERSAMPLE + 1);

    localparam logic [CW-1:0] CNT_V0 = CW'(H - 1);
    localparam logic [CW-1:0] CNT_V1 = CW'(H);
    localparam logic [CW-1:0] CNT_V2 = CW'(H + 1);
    localparam logic [CW-1:0] CNT_L  = CW'(L);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VERIFY,
        S_DECIDE,
        S_LOCKOUT,
        S_REARM
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_sample_q, prev_sample_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             vote_q, vote_d;
    logic                   start_detected_q, start_detected_d;
    logic                   false_start_q, false_start_d;
    logic                   busy_q, busy_d;

    logic          sample;
    logic [CW-1:0] cnt_inc;
    logic          vote_ok;

    assign sample  = sync_q[SYNC_STAGES-1];
    assign cnt_inc = cnt_q + CW'(1);
    // vote bits are 1 for a low sample; two of three low confirms the start bit
    assign vote_ok = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) | (vote_q[1] & vote_q[2]);

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        vote_d           = vote_q;
        sync_d           = {sync_q[SYNC_STAGES-2:0], serial_in};
        prev_sample_d    = sample_tick ? sample : prev_sample_q;
        start_detected_d = 1'b0;
        false_start_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sample_tick && prev_sample_q && !sample) begin
                    state_d = S_VERIFY;
                    cnt_d   = '0;
                    vote_d  = '0;
                end
            end
            S_VERIFY: begin
                if (sample_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_V0) vote_d[0] = ~sample;
                    if (cnt_inc == CNT_V1) vote_d[1] = ~sample;
                    if (cnt_inc == CNT_V2) begin
                        vote_d[2] = ~sample;
                        state_d   = S_DECIDE;
                    end
                end
            end
            S_DECIDE: begin
                if (vote_ok) begin
                    start_detected_d = 1'b1;
                    state_d          = S_LOCKOUT;
                    // a tick landing on the decision clock still counts toward the frame
                    cnt_d            = {{(CW-1){1'b0}}, sample_tick};
                end else begin
                    false_start_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (sample_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_L) state_d = S_REARM;
                end
            end
            S_REARM: begin
                if (sample_tick && sample) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q           <= '1;
            prev_sample_q    <= 1'b1;
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            vote_q           <= '0;
            start_detected_q <= 1'b0;
            false_start_q    <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            sync_q           <= sync_d;
            prev_sample_q    <= prev_sample_d;
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            vote_q           <= vote_d;
            start_detected_q <= start_detected_d;
            false_start_q    <= false_start_d;
            busy_q           <= busy_d;
        end
    end

    assign start_detected = start_detected_q;
    assign false_start    = false_start_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_uart_start_bit_validator.sv
// tb/tb_uart_start_bit_validator.sv - directed and randomized bench for uart_start_bit_validator
module tb_uart_start_bit_validator;
    localparam int OS = 16;
    localparam int SS = 2;
    localparam int FB = 10;
    localparam int H  = OS / 2;
    localparam int L  = (FB - 1) * OS - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sample_tick = 1'b0;
    logic serial_in = 1'b1;
    logic start_detected, false_start, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int per = 4;
    int chg_cyc = 0;
    int frame_fall = 0;

    uart_start_bit_validator #(
        .OVERSAMPLE (OS),
        .SYNC_STAGES(SS),
        .FRAME_BITS (FB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .serial_in     (serial_in),
        .start_detected(start_detected),
        .false_start   (false_start),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Frame-timeline model: after an accepted edge everything is a function of
    // the tick offset from that edge tick.
    bit dly[$];
    bit pv, in_frame, locked, decide, m_sd, m_fs, smp;
    int off, lows;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            dly.delete();
            for (int i = 0; i < SS; i++) dly.push_back(1'b1);
            pv = 1'b1; in_frame = 1'b0; locked = 1'b0; decide = 1'b0;
            m_sd = 1'b0; m_fs = 1'b0;
        end else begin
            smp = dly.pop_front();
            dly.push_back(serial_in);
            m_sd = 1'b0; m_fs = 1'b0;
            if (decide) begin
                decide = 1'b0;
                if (lows >= 2) begin m_sd = 1'b1; locked = 1'b1; end
                else begin m_fs = 1'b1; in_frame = 1'b0; end
            end else if (sample_tick) begin
                if (!in_frame) begin
                    if (pv && !smp) begin in_frame = 1'b1; off = 0; lows = 0; locked = 1'b0; end
                end else begin
                    off++;
                    if (!locked) begin
                        if (off >= H - 1 && !smp) lows++;
                        if (off == H + 1) decide = 1'b1;
                    end else if (off > H + 1 + L && smp) begin
                        in_frame = 1'b0;
                    end
                end
            end
            if (sample_tick) pv = smp;
        end
    end

    int sd_n, fs_n, fs_cyc, busy_fall_cyc, busy_hi_n;
    int sd_cycs[$];
    bit busy_prev;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic expect_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("busy", busy, in_frame);
            chk("start_detected", start_detected, m_sd);
            chk("false_start", false_start, m_fs);
            if (start_detected === 1'b1) begin sd_n++; sd_cycs.push_back(cyc); end
            if (false_start === 1'b1) begin fs_n++; fs_cyc = cyc; end
            if (busy === 1'b1) busy_hi_n++;
            if (busy_prev && busy === 1'b0) busy_fall_cyc = cyc;
            busy_prev = (busy === 1'b1);
        end
    end

    task automatic clr();
        sd_n = 0; fs_n = 0; fs_cyc = 0; busy_fall_cyc = 0; busy_hi_n = 0;
        sd_cycs.delete();
    endtask

    task automatic step(input logic t, input logic line);
        @(posedge clk);
        #1;
        if (serial_in !== line) chg_cyc = cyc + 1;
        sample_tick = t;
        serial_in   = line;
    endtask

    task automatic run_ticks(input int n, input logic line);
        for (int k = 0; k < n; k++)
            for (int p = 0; p < per; p++) step(p == per - 1, line);
    endtask

    task automatic send_frame(input logic [7:0] d);
        run_ticks(OS, 1'b0);
        frame_fall = chg_cyc;
        for (int b = 0; b < 8; b++) run_ticks(OS, d[b]);
        run_ticks(OS, 1'b1);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        reset = 1'b1; sample_tick = 1'b0; serial_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int f;
    logic [7:0] rb;

    initial begin
        clr();
        do_reset(3);

        // idle line after reset
        clr();
        run_ticks(25, 1'b1);
        expect_int("t1_sd_count", sd_n, 0);
        expect_int("t1_fs_count", fs_n, 0);
        expect_int("t1_busy_cycles", busy_hi_n, 0);

        // 0x55 frame: one detection, 40 clocks after the line falls at 4 clk/tick
        clr();
        send_frame(8'h55);
        f = frame_fall;
        run_ticks(40, 1'b1);
        expect_int("t2_sd_count", sd_n, 1);
        expect_int("t2_fs_count", fs_n, 0);
        if (sd_cycs.size() > 0) expect_int("t2_sd_latency", sd_cycs[0] - f, 40);
        expect_int("t2_busy_fall", busy_fall_cyc - f, 3 + 153 * 4);

        // three-tick glitch
        clr();
        run_ticks(3, 1'b0);
        f = chg_cyc;
        run_ticks(30, 1'b1);
        expect_int("t3_fs_count", fs_n, 1);
        expect_int("t3_sd_count", sd_n, 0);
        expect_int("t3_fs_latency", fs_cyc - f, 40);
        expect_int("t3_busy_idle", int'(busy), 0);

        // high glitch over sample tick H only
        clr();
        run_ticks(H, 1'b0);
        f = chg_cyc;
        run_ticks(1, 1'b1);
        run_ticks(OS - H - 1, 1'b0);
        for (int b = 0; b < 8; b++) run_ticks(OS, b[0]);
        run_ticks(OS + 20, 1'b1);
        expect_int("t4_sd_count", sd_n, 1);
        expect_int("t4_fs_count", fs_n, 0);
        if (sd_cycs.size() > 0) expect_int("t4_sd_latency", sd_cycs[0] - f, 40);

        // stop bit held low for 40 bit times, then a normal frame
        clr();
        run_ticks(OS, 1'b0);
        for (int b = 0; b < 8; b++) run_ticks(OS, (b < 4));
        run_ticks(OS * 40, 1'b0);
        expect_int("t5_busy_rearm", int'(busy), 1);
        expect_int("t5_sd_once", sd_n, 1);
        run_ticks(20, 1'b1);
        expect_int("t5_busy_released", int'(busy), 0);
        send_frame(8'h3C);
        run_ticks(20, 1'b1);
        expect_int("t5_sd_count", sd_n, 2);

        // back-to-back frames
        clr();
        send_frame(8'h96);
        send_frame(8'h69);
        run_ticks(20, 1'b1);
        expect_int("t6_sd_count", sd_n, 2);
        if (sd_cycs.size() == 2) expect_int("t6_spacing", sd_cycs[1] - sd_cycs[0], 160 * per);

        // reset during lockout
        run_ticks(OS, 1'b0);
        run_ticks(40, 1'b1);
        expect_int("t6_busy_lockout", int'(busy), 1);
        @(posedge clk);
        #1;
        reset = 1'b1; sample_tick = 1'b0; serial_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        expect_int("t6_busy_after_reset", int'(busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clr();
        run_ticks(20, 1'b1);
        send_frame(8'h5A);
        run_ticks(20, 1'b1);
        expect_int("t6_sd_after_reset", sd_n, 1);

        // randomized traffic checked cycle by cycle against the model
        for (int it = 0; it < 25; it++) begin
            per = $urandom_range(5, 2);
            case ($urandom_range(3, 0))
                0: begin
                    rb = 8'($urandom);
                    send_frame(rb);
                end
                1: begin
                    run_ticks($urandom_range(12, 1), 1'b0);
                    run_ticks(12, 1'b1);
                end
                2: begin
                    for (int k = 0; k < OS; k++)
                        run_ticks(1, (k >= H - 3 && k <= H + 3 && $urandom_range(2, 0) == 0));
                    rb = 8'($urandom);
                    for (int b = 0; b < 8; b++) run_ticks(OS, rb[b]);
                    run_ticks(OS, 1'b1);
                end
                default: begin
                    run_ticks(OS, 1'b0);
                    run_ticks($urandom_range(60, 1), 1'($urandom));
                    do_reset(1);
                    run_ticks(4, 1'b1);
                end
            endcase
            run_ticks($urandom_range(20, 0), 1'b1);
        end
        run_ticks(170, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
